bcd_serial_addsub: RTL and testbench

//  Parametrised multi-digit BCD adder/subtractor; successor to the fixed 2-digit combinational BCD adder.

---
 rtl/bcd_serial_addsub.sv | 129 ++++++++++++
 tb/tb_bcd_serial_addsub.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first, valid/ready on both sides.
// Optional input digit check enabled by defining BCD_CHECK_EN.
module bcd_serial_addsub #(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NDIGITS-1:0] in_a,
    input  logic [4*NDIGITS-1:0] in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIGITS-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_err
);

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, b_adj;
    logic           sub_q, carry_q;
    logic [IW-1:0]  idx_q;
    logic [4:0]     s5;
    logic           gt9;
    logic [3:0]     digit;
    logic           accept, last;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (idx_q == IW'(NDIGITS - 1));

    // Subtraction runs as A + (nines' complement of B) + ~borrow_in
    always_comb begin
        b_adj = in_b;
        if (in_sub) begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                b_adj[4*i +: 4] = 4'd9 - in_b[4*i +: 4];
            end
        end
    end

    // Single-digit decimal adder for the current LSD
    always_comb begin
        s5    = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(carry_q);
        gt9   = (s5 > 5'd9);
        digit = gt9 ? 4'(s5 + 5'd6) : s5[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == DONE);
            if (accept) begin
                a_q     <= in_a;
                b_q     <= b_adj;
                sub_q   <= in_sub;
                carry_q <= in_sub ? ~in_cin : in_cin;
                idx_q   <= '0;
            end else if (state_q == CALC) begin
                a_q     <= a_q >> 4;
                b_q     <= b_q >> 4;
                carry_q <= gt9;
                idx_q   <= idx_q + IW'(1);
                out_sum <= (out_sum >> 4) | (W'(digit) << (W - 4));
                if (last) begin
                    out_cout <= sub_q ? ~gt9 : gt9;
                end
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (in_a[4*i +: 4] > 4'd9 || in_b[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Flag is captured at accept and held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (accept) begin
            out_err <= bad_digit;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (NDIGITS=4): directed table, handshake/reset
// sequences, and random operands against an integer-arithmetic decimal model.
module tb_bcd_serial_addsub;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;
`ifdef BCD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, out_err;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_serial_addsub #(.NDIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        logic         chk_sum;
    } vec_t;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = int'(N) - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < int'(N); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: exact decimal arithmetic modulo 10^N
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] sum, output logic cout);
        longint m = 1;
        longint r;
        for (int i = 0; i < int'(N); i++) m = m * 10;
        if (sub) r = bcd2int(a) - bcd2int(b) - longint'(cin);
        else     r = bcd2int(a) + bcd2int(b) + longint'(cin);
        cout = sub ? (r < 0) : (r >= m);
        sum  = int2bcd((r + m) % m);
    endtask

    // Called #1 after a clock edge; returns #1 after the edge where out_valid is seen
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output int lat);
        check("in_ready_before_accept", longint'(in_ready), 1);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(posedge clk); #1;
        check("out_valid_drop", longint'(out_valid), 0);
        check("in_ready_after_consume", longint'(in_ready), 1);
    endtask

    vec_t         vecs[9];
    int           lat;
    logic [W-1:0] e_sum, held_sum, ra, rb;
    logic         e_cout, held_cout;

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h0100, 16'h0200, 1'b0, 1'b1, 16'h9900, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, CHK,  1'b0};
        vecs[6] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        #12;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_sum", longint'(out_sum), 0);
        check("reset_out_cout", longint'(out_cout), 0);
        check("reset_out_err", longint'(out_err), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), longint'(lat), longint'(N));
            if (vecs[i].chk_sum) begin
                check($sformatf("vec%0d_sum", i), longint'(out_sum), longint'(vecs[i].sum));
                check($sformatf("vec%0d_cout", i), longint'(out_cout), longint'(vecs[i].cout));
            end
            check($sformatf("vec%0d_err", i), longint'(out_err), longint'(vecs[i].err));
            consume();
        end

        // Result held under backpressure; input pulses ignored
        out_ready = 1'b0;
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
        held_sum = out_sum; held_cout = out_cout;
        check("bp_sum", longint'(held_sum), 16'h6912);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0); in_a = 16'h4444; in_b = 16'h3333; in_sub = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_sum_stable", longint'(out_sum), longint'(held_sum));
            check("bp_cout_stable", longint'(out_cout), longint'(held_cout));
            check("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        consume();

        // Reset during CALC aborts; next op unaffected
        in_a = 16'h1234; in_b = 16'h5678; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", longint'(out_valid), 0);
        check("midreset_out_sum", longint'(out_sum), 0);
        check("midreset_in_ready", longint'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0, lat);
        check("postreset_latency", longint'(lat), longint'(N));
        check("postreset_sum", longint'(out_sum), 16'h0010);
        check("postreset_cout", longint'(out_cout), 0);
        consume();

        // Random legal BCD operands against the decimal model
        for (int k = 0; k < 60; k++) begin
            for (int d = 0; d < int'(N); d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            in_cin = 1'($urandom_range(0, 1));
            in_sub = 1'($urandom_range(0, 1));
            model(ra, rb, in_cin, in_sub, e_sum, e_cout);
            run_op(ra, rb, in_cin, in_sub, lat);
            check("rand_latency", longint'(lat), longint'(N));
            check("rand_sum", longint'(out_sum), longint'(e_sum));
            check("rand_cout", longint'(out_cout), longint'(e_cout));
            check("rand_err", longint'(out_err), 0);
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
